// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and default hitbox sizes for the collision array
package collision_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNAP   = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int DEF_PW = 26;
    localparam int DEF_PH = 32;
    localparam int DEF_EW = 32;
    localparam int DEF_EH = 32;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - strict axis-aligned box overlap test on 11-bit sums
module box_overlap
    import collision_pkg::*;
#(
    parameter int AW = DEF_PW,
    parameter int AH = DEF_PH,
    parameter int BW = DEF_EW,
    parameter int BH = DEF_EH
) (
    input  coord_t ax,
    input  coord_t ay,
    input  coord_t bx,
    input  coord_t by,
    output logic   hit
);

    // Widen to 11 bits so coordinate + size never wraps near the 10-bit limit
    logic [10:0] ax_w, ay_w, bx_w, by_w;

    assign ax_w = {1'b0, ax};
    assign ay_w = {1'b0, ay};
    assign bx_w = {1'b0, bx};
    assign by_w = {1'b0, by};

    // Touching edges do not count as overlap
    assign hit = (ax_w < bx_w + 11'(BW)) && (bx_w < ax_w + 11'(AW)) &&
                 (ay_w < by_w + 11'(BH)) && (by_w < ay_w + 11'(AH));

endmodule

// File: rtl/collision_array.sv
// rtl/collision_array.sv - per-frame player/enemy collision scan with sticky dead flags
module collision_array
    import collision_pkg::*;
#(
    parameter int N_PLAYER = 2,
    parameter int N_ENEMY  = 4,
    parameter int PW       = DEF_PW,
    parameter int PH       = DEF_PH,
    parameter int EW       = DEF_EW,
    parameter int EH       = DEF_EH
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_Clk,
    input  logic                    clear,
    input  logic [10*N_PLAYER-1:0]  player_x,
    input  logic [10*N_PLAYER-1:0]  player_y,
    input  logic [10*N_PLAYER-1:0]  player_y_mot,
    input  logic [10*N_ENEMY-1:0]   enemy_x,
    input  logic [10*N_ENEMY-1:0]   enemy_y,
    input  logic [9:0]              process,
    output logic [N_PLAYER-1:0]     player_dead,
    output logic [N_ENEMY-1:0]      enemy_dead,
    output logic [N_ENEMY-1:0]      stomp_pulse,
    output logic                    scan_done
);

    localparam int PIW = (N_PLAYER > 1) ? $clog2(N_PLAYER) : 1;
    localparam int EIW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [PIW-1:0] P_LAST = PIW'(N_PLAYER - 1);
    localparam logic [EIW-1:0] E_LAST = EIW'(N_ENEMY - 1);

    state_t                   state_q, state_d;
    logic [2:0]               sync_q, sync_d;
    logic [PIW-1:0]           p_idx_q, p_idx_d;
    logic [EIW-1:0]           e_idx_q, e_idx_d;
    logic [10*N_PLAYER-1:0]   snap_px_q, snap_px_d, snap_py_q, snap_py_d, snap_pm_q, snap_pm_d;
    logic [10*N_ENEMY-1:0]    snap_ex_q, snap_ex_d, snap_ey_q, snap_ey_d;
    logic [N_PLAYER-1:0]      snap_pdead_q, snap_pdead_d, pkill_q, pkill_d;
    logic [N_ENEMY-1:0]       snap_edead_q, snap_edead_d, ekill_q, ekill_d;
    logic [N_PLAYER-1:0]      player_dead_q, player_dead_d;
    logic [N_ENEMY-1:0]       enemy_dead_q, enemy_dead_d;
    logic [N_ENEMY-1:0]       stomp_q, stomp_d;
    logic                     done_q, done_d;

    logic                     frame_rise;
    coord_t                   cur_px, cur_py, cur_pm, cur_ex, cur_ey;
    logic                     pair_hit, pair_live, falling;
    logic [N_ENEMY-1:0]       offscreen;

    assign frame_rise = sync_q[1] & ~sync_q[2];

    assign cur_px = snap_px_q[10*p_idx_q +: 10];
    assign cur_py = snap_py_q[10*p_idx_q +: 10];
    assign cur_pm = snap_pm_q[10*p_idx_q +: 10];
    assign cur_ex = snap_ex_q[10*e_idx_q +: 10];
    assign cur_ey = snap_ey_q[10*e_idx_q +: 10];

    assign pair_live = !snap_pdead_q[p_idx_q] && !snap_edead_q[e_idx_q];
    assign falling   = !cur_pm[9] && (cur_pm != '0);

    box_overlap #(
        .AW (PW),
        .AH (PH),
        .BW (EW),
        .BH (EH)
    ) u_overlap (
        .ax  (cur_px),
        .ay  (cur_py),
        .bx  (cur_ex),
        .by  (cur_ey),
        .hit (pair_hit)
    );

    // Enemies scrolled past the left edge of the view
    always_comb begin
        offscreen = '0;
        for (int e = 0; e < N_ENEMY; e++) begin
            offscreen[e] = snap_ex_q[10*e +: 10] < process;
        end
    end

    // Next-state: frame FSM, pair walk, snapshot capture, kill accumulation, commit
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[1:0], frame_Clk};
        p_idx_d       = p_idx_q;
        e_idx_d       = e_idx_q;
        snap_px_d     = snap_px_q;
        snap_py_d     = snap_py_q;
        snap_pm_d     = snap_pm_q;
        snap_ex_d     = snap_ex_q;
        snap_ey_d     = snap_ey_q;
        snap_pdead_d  = snap_pdead_q;
        snap_edead_d  = snap_edead_q;
        pkill_d       = pkill_q;
        ekill_d       = ekill_q;
        player_dead_d = player_dead_q;
        enemy_dead_d  = enemy_dead_q;
        stomp_d       = '0;
        done_d        = 1'b0;

        if (clear) begin
            state_d       = IDLE;
            p_idx_d       = '0;
            e_idx_d       = '0;
            pkill_d       = '0;
            ekill_d       = '0;
            player_dead_d = '0;
            enemy_dead_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_rise) state_d = SNAP;
                end
                SNAP: begin
                    snap_px_d    = player_x;
                    snap_py_d    = player_y;
                    snap_pm_d    = player_y_mot;
                    snap_ex_d    = enemy_x;
                    snap_ey_d    = enemy_y;
                    snap_pdead_d = player_dead_q;
                    snap_edead_d = enemy_dead_q;
                    pkill_d      = '0;
                    ekill_d      = '0;
                    p_idx_d      = '0;
                    e_idx_d      = '0;
                    state_d      = SCAN;
                end
                SCAN: begin
                    if (pair_live && pair_hit) begin
                        if (falling) ekill_d[e_idx_q] = 1'b1;
                        else         pkill_d[p_idx_q] = 1'b1;
                    end
                    if (e_idx_q == E_LAST) begin
                        e_idx_d = '0;
                        if (p_idx_q == P_LAST) begin
                            p_idx_d = '0;
                            state_d = COMMIT;
                        end else begin
                            p_idx_d = p_idx_q + 1'b1;
                        end
                    end else begin
                        e_idx_d = e_idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    player_dead_d = player_dead_q | pkill_q;
                    enemy_dead_d  = enemy_dead_q | ekill_q | offscreen;
                    stomp_d       = ekill_q & ~enemy_dead_q;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            p_idx_q       <= '0;
            e_idx_q       <= '0;
            snap_px_q     <= '0;
            snap_py_q     <= '0;
            snap_pm_q     <= '0;
            snap_ex_q     <= '0;
            snap_ey_q     <= '0;
            snap_pdead_q  <= '0;
            snap_edead_q  <= '0;
            pkill_q       <= '0;
            ekill_q       <= '0;
            player_dead_q <= '0;
            enemy_dead_q  <= '0;
            stomp_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            p_idx_q       <= p_idx_d;
            e_idx_q       <= e_idx_d;
            snap_px_q     <= snap_px_d;
            snap_py_q     <= snap_py_d;
            snap_pm_q     <= snap_pm_d;
            snap_ex_q     <= snap_ex_d;
            snap_ey_q     <= snap_ey_d;
            snap_pdead_q  <= snap_pdead_d;
            snap_edead_q  <= snap_edead_d;
            pkill_q       <= pkill_d;
            ekill_q       <= ekill_d;
            player_dead_q <= player_dead_d;
            enemy_dead_q  <= enemy_dead_d;
            stomp_q       <= stomp_d;
            done_q        <= done_d;
        end
    end

    assign player_dead = player_dead_q;
    assign enemy_dead  = enemy_dead_q;
    assign stomp_pulse = stomp_q;
    assign scan_done   = done_q;

endmodule

// File: tb/tb_collision_array.sv
// tb/tb_collision_array.sv - randomized scoreboard bench for collision_array
module tb_collision_array;

    localparam int NP  = 2;
    localparam int NE  = 4;
    localparam int PW  = 26;
    localparam int PH  = 32;
    localparam int EW  = 32;
    localparam int EH  = 32;
    localparam int LAT = NP*NE + 5;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               frame_Clk;
    logic               clear;
    logic [10*NP-1:0]   player_x, player_y, player_y_mot;
    logic [10*NE-1:0]   enemy_x, enemy_y;
    logic [9:0]         process;
    logic [NP-1:0]      player_dead;
    logic [NE-1:0]      enemy_dead;
    logic [NE-1:0]      stomp_pulse;
    logic               scan_done;

    collision_array #(
        .N_PLAYER (NP),
        .N_ENEMY  (NE),
        .PW       (PW),
        .PH       (PH),
        .EW       (EW),
        .EH       (EH)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_Clk    (frame_Clk),
        .clear        (clear),
        .player_x     (player_x),
        .player_y     (player_y),
        .player_y_mot (player_y_mot),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .process      (process),
        .player_dead  (player_dead),
        .enemy_dead   (enemy_dead),
        .stomp_pulse  (stomp_pulse),
        .scan_done    (scan_done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [NP-1:0] pd;
        logic [NE-1:0] ed;
        logic [NE-1:0] st;
        int            t;
    } exp_t;

    exp_t q[$];
    exp_t mx;

    int tests = 0;
    int fails = 0;

    int px[NP], py[NP], pm[NP];
    int ex[NE], ey[NE];
    int proc;
    logic [NP-1:0] mpdead;
    logic [NE-1:0] medead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            player_x[10*i +: 10]     = 10'(px[i]);
            player_y[10*i +: 10]     = 10'(py[i]);
            player_y_mot[10*i +: 10] = 10'(pm[i]);
        end
        for (int i = 0; i < NE; i++) begin
            enemy_x[10*i +: 10] = 10'(ex[i]);
            enemy_y[10*i +: 10] = 10'(ey[i]);
        end
        process = 10'(proc);
    endtask

    function automatic bit boxes_touch(input int p, input int e);
        return (px[p] < ex[e] + EW) && (ex[e] < px[p] + PW) &&
               (py[p] < ey[e] + EH) && (ey[e] < py[p] + PH);
    endfunction

    // Reference: every live pair that touches either stomps (player falling) or kills the player
    task automatic issue_frame();
        exp_t          x;
        logic [NP-1:0] pk = '0;
        logic [NE-1:0] ek = '0;
        drive_inputs();
        for (int p = 0; p < NP; p++)
            for (int e = 0; e < NE; e++)
                if (!mpdead[p] && !medead[e] && boxes_touch(p, e)) begin
                    if (pm[p] > 0) ek[e] = 1'b1;
                    else           pk[p] = 1'b1;
                end
        x.st   = ek & ~medead;
        mpdead = mpdead | pk;
        medead = medead | ek;
        for (int e = 0; e < NE; e++)
            if (ex[e] < proc) medead[e] = 1'b1;
        x.pd = mpdead;
        x.ed = medead;
        x.t  = cyc + LAT;
        q.push_back(x);
        pulse_frame();
    endtask

    task automatic pulse_frame();
        frame_Clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 frame_Clk = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge Clk);
            n++;
        end
        #1;
        if (q.size() > 0) begin
            check("scan_done_timeout", 32'(q.size()), 0);
            q.delete();
        end
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge Clk);
        #1 clear = 1'b0;
        mpdead = '0;
        medead = '0;
        check("clear_player_dead", 32'(player_dead), 0);
        check("clear_enemy_dead", 32'(enemy_dead), 0);
    endtask

    task automatic set_scene();
        px[0] = 100; py[0] = 200; pm[0] = 0;
        px[1] = 500; py[1] = 500; pm[1] = 0;
        for (int e = 0; e < NE; e++) begin
            ex[e] = 900;
            ey[e] = 50;
        end
        ex[0] = 110; ey[0] = 210;
        proc = 0;
    endtask

    function automatic int rand_coord();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 150));
    endfunction

    // Scoreboard monitor: every scan_done must match the oldest expected frame
    always @(negedge Clk) begin
        if (Reset) begin
            if (scan_done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_scan_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mx = q.pop_front();
                    check("player_dead", 32'(player_dead), 32'(mx.pd));
                    check("enemy_dead", 32'(enemy_dead), 32'(mx.ed));
                    check("stomp_pulse", 32'(stomp_pulse), 32'(mx.st));
                    check("scan_latency", 32'(cyc), 32'(mx.t));
                end
            end else begin
                check("stomp_idle", 32'(stomp_pulse), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        frame_Clk = 1'b0;
        clear = 1'b0;
        mpdead = '0;
        medead = '0;
        set_scene();
        drive_inputs();
        repeat (3) @(posedge Clk);
        #1;
        check("reset_player_dead", 32'(player_dead), 0);
        check("reset_enemy_dead", 32'(enemy_dead), 0);
        check("reset_stomp", 32'(stomp_pulse), 0);
        check("reset_scan_done", 32'(scan_done), 0);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Stomp
        set_scene(); pm[0] = 3;
        issue_frame(); wait_drain();

        // Plain hit
        do_clear(); set_scene();
        issue_frame(); wait_drain();

        // Touching right edge, then one pixel of overlap
        do_clear(); set_scene(); ex[0] = 126; ey[0] = 200;
        issue_frame(); wait_drain();
        ex[0] = 125;
        issue_frame(); wait_drain();

        // Off-screen enemy only
        do_clear(); set_scene(); proc = 300; ex[0] = 900; ex[2] = 299;
        issue_frame(); wait_drain();

        // One player stomps E1 while the other is hit by it
        do_clear(); set_scene(); ex[0] = 900;
        pm[0] = 3; px[1] = 120; py[1] = 200; pm[1] = 0;
        ex[1] = 110; ey[1] = 210;
        issue_frame(); wait_drain();

        // Clear mid-scan: no scan_done, flags zero
        set_scene();
        pulse_frame();
        repeat (4) @(posedge Clk);
        #1;
        do_clear();
        repeat (20) @(posedge Clk);
        #1;
        check("midclear_player_dead", 32'(player_dead), 0);

        // Reset mid-scan
        set_scene();
        issue_frame(); wait_drain();
        pulse_frame();
        repeat (4) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check("midreset_player_dead", 32'(player_dead), 0);
        check("midreset_enemy_dead", 32'(enemy_dead), 0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        mpdead = '0;
        medead = '0;
        repeat (20) @(posedge Clk);
        #1;

        // Second edge during scan is dropped
        set_scene(); pm[0] = 3;
        issue_frame();
        repeat (4) @(posedge Clk);
        #1;
        pulse_frame();
        wait_drain();
        repeat (20) @(posedge Clk);
        #1;

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            for (int p = 0; p < NP; p++) begin
                px[p] = rand_coord();
                py[p] = rand_coord();
                case ($urandom_range(0, 7))
                    0:       pm[p] = 511;
                    1:       pm[p] = -512;
                    default: pm[p] = int'($urandom_range(0, 10)) - 5;
                endcase
            end
            for (int e = 0; e < NE; e++) begin
                ex[e] = rand_coord();
                ey[e] = rand_coord();
            end
            proc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : 0;
            issue_frame();
            wait_drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
